// File: rtl/corelet_pkg.sv
// corelet_pkg: shared types and constants for the corelet sequencer.
// Holds the state enum, array instruction codes and default sizes.
package corelet_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_LOAD,
    W_PUSH,
    W_SETTLE,
    A_LOAD,
    A_EXEC,
    DRAIN,
    CLEAR,
    WB,
    DONE
  } seq_state_e;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  localparam int ROW_DEF       = 8;
  localparam int COL_DEF       = 8;
  localparam int MAX_KIJ_DEF   = 9;
  localparam int ACT_DEPTH_DEF = 64;
  localparam int OUT_DEPTH_DEF = 16;

endpackage

// File: rtl/sram_to_l0_issuer.sv
// sram_to_l0_issuer: SRAM read issue counter feeding the L0 FIFO.
// Reads are held off by l0_full; the L0 write trails each read by one cycle.
module sram_to_l0_issuer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_active,
  input  logic          i_clr,
  input  logic [CW-1:0] i_len,
  input  logic          i_full,
  output logic [CW-1:0] o_cnt,
  output logic          o_cen,
  output logic          o_wr,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;
  logic          r_wr;
  logic          w_pend;
  logic          w_issue;

  assign w_pend  = i_active && (r_cnt != i_len);
  assign w_issue = w_pend && !i_full;
  assign o_cnt   = r_cnt;
  assign o_cen   = !w_issue;
  assign o_wr    = r_wr;
  assign o_done  = i_active && (r_cnt == i_len);

  // Count issued reads; the write strobe is the read delayed by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_wr  <= 1'b0;
    end else if (i_clr || !i_active) begin
      r_cnt <= '0;
      r_wr  <= 1'b0;
    end else begin
      r_wr <= w_issue;
      if (w_issue) r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/corelet_seq_ctrl.sv
// corelet_seq_ctrl: weight/activation load, execute and writeback sequencer.
// Optional busy/stall perf counters are built when CORELET_SEQ_PERF_EN is defined.
module corelet_seq_ctrl
  import corelet_pkg::*;
#(
  parameter int ROW       = ROW_DEF,
  parameter int COL       = COL_DEF,
  parameter int MAX_KIJ   = MAX_KIJ_DEF,
  parameter int ACT_DEPTH = ACT_DEPTH_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int W_AW      = $clog2(MAX_KIJ*ROW),
  parameter int A_AW      = $clog2(ACT_DEPTH),
  parameter int O_AW      = $clog2(OUT_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       seq_begin,
  input  logic                       seq_abort,
  input  logic [$clog2(MAX_KIJ)-1:0] cfg_kij,
  input  logic [A_AW-1:0]            cfg_n_act,
  output logic                       busy,
  output logic                       seq_done,
  output logic                       sfu_done,
  output logic                       sel_w,
  output logic [W_AW-1:0]            w_addr,
  output logic                       w_cen,
  output logic [A_AW-1:0]            act_addr,
  output logic                       act_cen,
  output logic                       l0_wr,
  output logic                       l0_rd,
  input  logic                       l0_full,
  input  logic                       l0_ready,
  output logic [1:0]                 inst_w,
  output logic                       array_clr,
  output logic [O_AW-1:0]            op_addr,
  output logic                       op_cen,
  output logic                       op_wen,
  output logic [O_AW-1:0]            out_sel
`ifdef CORELET_SEQ_PERF_EN
  ,
  output logic [31:0]                perf_cycles,
  output logic [31:0]                perf_stalls
`endif
);

  localparam int KW = $clog2(MAX_KIJ);
  localparam int CW = $clog2(ACT_DEPTH + ROW + COL + OUT_DEPTH) + 1;

  seq_state_e      r_state;
  logic [CW-1:0]   r_cnt;
  logic [KW-1:0]   r_kij;
  logic [KW-1:0]   r_cfg_kij;
  logic [A_AW-1:0] r_cfg_n_act;
  logic            r_abort_clr;

  logic          w_in_w;
  logic          w_in_a;
  logic          w_iss_act;
  logic          w_push;
  logic          w_exec;
  logic          w_rd_ok;
  logic          w_abort;
  logic          w_wb;
  logic [CW-1:0] w_iss_len;
  logic [CW-1:0] w_icnt;
  logic          w_icen;
  logic          w_iwr;
  logic          w_idone;

  assign w_in_w    = (r_state == W_LOAD);
  assign w_in_a    = (r_state == A_LOAD);
  assign w_iss_act = w_in_w || w_in_a;
  assign w_push    = (r_state == W_PUSH);
  assign w_exec    = (r_state == A_EXEC);
  assign w_wb      = (r_state == WB);
  assign w_rd_ok   = (w_push || w_exec) && l0_ready;
  assign w_abort   = seq_abort && (r_state != IDLE);
  assign w_iss_len = w_in_w ? CW'(ROW)
                            : CW'(r_cfg_n_act) + CW'(1);

  sram_to_l0_issuer #(
    .CW (CW)
  ) u_issuer (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_active (w_iss_act),
    .i_clr    (w_abort),
    .i_len    (w_iss_len),
    .i_full   (l0_full),
    .o_cnt    (w_icnt),
    .o_cen    (w_icen),
    .o_wr     (w_iwr),
    .o_done   (w_idone)
  );

  assign busy      = (r_state != IDLE);
  assign seq_done  = (r_state == DONE);
  assign sfu_done  = w_wb;
  assign sel_w     = w_in_w || w_push;
  assign w_cen     = w_in_w ? w_icen : 1'b1;
  assign w_addr    = w_in_w ? W_AW'(int'(r_kij) * ROW + int'(w_icnt)) : '0;
  assign act_cen   = w_in_a ? w_icen : 1'b1;
  assign act_addr  = w_in_a ? w_icnt[A_AW-1:0] : '0;
  assign l0_wr     = w_iwr;
  assign l0_rd     = w_rd_ok;
  assign inst_w    = !w_rd_ok ? INST_IDLE
                   : (w_push ? INST_KLOAD : INST_EXEC);
  assign array_clr = (r_state == CLEAR) || r_abort_clr;
  assign op_cen    = !w_wb;
  assign op_wen    = !w_wb;
  assign op_addr   = w_wb ? r_cnt[O_AW-1:0] : '0;
  assign out_sel   = w_wb ? r_cnt[O_AW-1:0] : '0;

  // Main sequencer: phase transitions, phase counter and tap index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_kij       <= '0;
      r_cfg_kij   <= '0;
      r_cfg_n_act <= '0;
      r_abort_clr <= 1'b0;
    end else begin
      r_abort_clr <= 1'b0;
      if (w_abort) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_abort_clr <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: if (seq_begin) begin
            r_cfg_kij   <= cfg_kij;
            r_cfg_n_act <= cfg_n_act;
            r_kij       <= '0;
            r_cnt       <= '0;
            r_state     <= W_LOAD;
          end
          W_LOAD: if (w_idone) begin
            r_cnt   <= '0;
            r_state <= W_PUSH;
          end
          W_PUSH: if (l0_ready) begin
            if (r_cnt == CW'(ROW - 1)) begin
              r_cnt   <= '0;
              r_state <= W_SETTLE;
            end else r_cnt <= r_cnt + CW'(1);
          end
          W_SETTLE: begin
            if (r_cnt == CW'(COL - 1)) begin
              r_cnt   <= '0;
              r_state <= A_LOAD;
            end else r_cnt <= r_cnt + CW'(1);
          end
          A_LOAD: if (w_idone) begin
            r_cnt   <= '0;
            r_state <= A_EXEC;
          end
          A_EXEC: if (l0_ready) begin
            if (r_cnt == CW'(r_cfg_n_act)) begin
              r_cnt   <= '0;
              r_state <= DRAIN;
            end else r_cnt <= r_cnt + CW'(1);
          end
          DRAIN: begin
            if (r_cnt == CW'(ROW + COL - 1)) begin
              r_cnt   <= '0;
              r_state <= CLEAR;
            end else r_cnt <= r_cnt + CW'(1);
          end
          CLEAR: begin
            r_cnt <= '0;
            if (r_kij == r_cfg_kij) begin
              r_state <= WB;
            end else begin
              r_kij   <= r_kij + KW'(1);
              r_state <= W_LOAD;
            end
          end
          WB: begin
            if (r_cnt == CW'(OUT_DEPTH - 1)) begin
              r_cnt   <= '0;
              r_state <= DONE;
            end else r_cnt <= r_cnt + CW'(1);
          end
          DONE: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef CORELET_SEQ_PERF_EN
  logic [31:0] r_perf_cyc;
  logic [31:0] r_perf_stl;
  logic        w_stall;

  assign w_stall = (w_iss_act && !w_idone && l0_full)
                || ((w_push || w_exec) && !l0_ready);

  // Saturating busy/stall counters, cleared when a run is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_cyc <= '0;
      r_perf_stl <= '0;
    end else if (r_state == IDLE && seq_begin) begin
      r_perf_cyc <= '0;
      r_perf_stl <= '0;
    end else if (busy) begin
      if (r_perf_cyc != '1) r_perf_cyc <= r_perf_cyc + 32'd1;
      if (w_stall && r_perf_stl != '1) r_perf_stl <= r_perf_stl + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cyc;
  assign perf_stalls = r_perf_stl;
`endif

endmodule

// File: tb/tb_corelet_seq_ctrl.sv
// tb_corelet_seq_ctrl: scenario bench for the corelet sequencer.
// Reads, strobes and completion timing are checked against arithmetic rules.
module tb_corelet_seq_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int OUT_DEPTH = 16;
  localparam int A_LOAD0 = ROW + 1 + ROW + COL;
  localparam int BUDGET = 4000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       seq_begin;
  logic       seq_abort;
  logic [3:0] cfg_kij;
  logic [5:0] cfg_n_act;
  logic       busy, seq_done, sfu_done, sel_w;
  logic [6:0] w_addr;
  logic       w_cen;
  logic [5:0] act_addr;
  logic       act_cen;
  logic       l0_wr, l0_rd;
  logic       l0_full, l0_ready;
  logic [1:0] inst_w;
  logic       array_clr;
  logic [3:0] op_addr;
  logic       op_cen, op_wen;
  logic [3:0] out_sel;
`ifdef CORELET_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  int n_chk;
  int n_fail;

  int mc_n_w, mc_w_bad, mc_n_a, mc_a_bad, mc_n_op, mc_op_bad;
  int mc_n_wr, mc_wr_bad, mc_n_exec, mc_n_kload, mc_n_clr;
  int mc_n_done, mc_done_cyc, mc_n_sel, mc_n_sfu, mc_stall_bad;
  int mc_timeout;
  logic [10:0] mc_snap;
  logic        mc_snap2;

  always #5 clk = ~clk;

  corelet_seq_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seq_begin (seq_begin),
    .seq_abort (seq_abort),
    .cfg_kij   (cfg_kij),
    .cfg_n_act (cfg_n_act),
    .busy      (busy),
    .seq_done  (seq_done),
    .sfu_done  (sfu_done),
    .sel_w     (sel_w),
    .w_addr    (w_addr),
    .w_cen     (w_cen),
    .act_addr  (act_addr),
    .act_cen   (act_cen),
    .l0_wr     (l0_wr),
    .l0_rd     (l0_rd),
    .l0_full   (l0_full),
    .l0_ready  (l0_ready),
    .inst_w    (inst_w),
    .array_clr (array_clr),
    .op_addr   (op_addr),
    .op_cen    (op_cen),
    .op_wen    (op_wen),
    .out_sel   (out_sel)
`ifdef CORELET_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
`endif
  );

  // Completion cycle (0 = first cycle after the start edge) from phase lengths
  function automatic int exp_done(input int k, input int n, input int stalls);
    int pass;
    pass = (ROW + 1) + ROW + COL + (n + 2) + (n + 1) + (ROW + COL) + 1;
    return (k + 1) * pass + OUT_DEPTH + stalls;
  endfunction

  // Start one run and observe it cycle by cycle until it returns to IDLE
  task automatic run_seq(input int k, input int n,
                         input int fs, input int fl,
                         input int rs, input int rl,
                         input int ab, input int stop);
    logic prev_rd;
    mc_n_w = 0; mc_w_bad = 0; mc_n_a = 0; mc_a_bad = 0;
    mc_n_op = 0; mc_op_bad = 0; mc_n_wr = 0; mc_wr_bad = 0;
    mc_n_exec = 0; mc_n_kload = 0; mc_n_clr = 0; mc_n_done = 0;
    mc_done_cyc = -1; mc_n_sel = 0; mc_n_sfu = 0; mc_stall_bad = 0;
    mc_timeout = 1; mc_snap = '0; mc_snap2 = 1'b1;
    prev_rd = 1'b0;
    @(posedge clk); #1;
    cfg_kij = 4'(k);
    cfg_n_act = 6'(n);
    seq_begin = 1'b1;
    @(posedge clk); #1;
    seq_begin = 1'b0;
    cfg_kij = 4'($urandom_range(0, 15));
    cfg_n_act = 6'($urandom_range(0, 63));
    for (int c = 0; c < BUDGET; c++) begin
      l0_full = (c >= fs) && (c < fs + fl);
      l0_ready = !((c >= rs) && (c < rs + rl));
      seq_abort = (c == ab);
      @(negedge clk);
      if (!w_cen) begin
        if (w_addr !== 7'(mc_n_w)) mc_w_bad++;
        mc_n_w++;
      end
      if (!act_cen) begin
        if (act_addr !== 6'(mc_n_a % (n + 1))) mc_a_bad++;
        mc_n_a++;
      end
      if (!op_cen) begin
        if (op_addr !== 4'(mc_n_op) || out_sel !== 4'(mc_n_op) || op_wen !== 1'b0)
          mc_op_bad++;
        mc_n_op++;
      end
      if (l0_wr !== prev_rd) mc_wr_bad++;
      if (l0_wr) mc_n_wr++;
      prev_rd = !w_cen || !act_cen;
      if (l0_rd && inst_w == 2'b10) mc_n_exec++;
      if (l0_rd && inst_w == 2'b01) mc_n_kload++;
      if (!l0_rd && inst_w != 2'b00) mc_stall_bad++;
      if (!l0_ready && (l0_rd || inst_w != 2'b00)) mc_stall_bad++;
      if (l0_full && (!w_cen || !act_cen)) mc_stall_bad++;
      if (array_clr) mc_n_clr++;
      if (seq_done) begin
        mc_n_done++;
        mc_done_cyc = c;
      end
      if (sel_w) mc_n_sel++;
      if (sfu_done) mc_n_sfu++;
      if (c == ab + 1)
        mc_snap = {busy, array_clr, l0_wr, l0_rd, inst_w,
                   w_cen, act_cen, op_cen, seq_done, sfu_done};
      if (c == ab + 2) mc_snap2 = array_clr;
      if (c == stop) begin
        mc_timeout = 0;
        break;
      end
      if (c > 0 && c > ab + 1 && !busy) begin
        mc_timeout = 0;
        break;
      end
      @(posedge clk); #1;
    end
    l0_full = 1'b0;
    l0_ready = 1'b1;
    seq_abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] v;
    logic [20:0] a;
    repeat (2) @(posedge clk);
    #1;
    v = {busy, seq_done, sfu_done, l0_wr, l0_rd, array_clr, inst_w,
         w_cen, act_cen, op_cen, op_wen, sel_w};
    a = {w_addr, act_addr, op_addr, out_sel};
    n_chk++;
    if (v !== 13'b000000_00_1111_0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want %b", v, 13'b000000_00_1111_0);
    end
    n_chk++;
    if (a !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 0", a);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0 || w_cen !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: busy %b w_cen %b want 0 1", busy, w_cen);
    end
  endtask

  task automatic test_single_pass();
    run_seq(0, 35, -10, 0, -10, 0, -10, -1);
    n_chk++;
    if (mc_timeout !== 0) begin
      n_fail++;
      $display("FAIL single_timeout: got %0d want 0", mc_timeout);
    end
    n_chk++;
    if (mc_done_cyc !== 131 || mc_n_done !== 1) begin
      n_fail++;
      $display("FAIL single_done: cycle %0d count %0d want 131 1", mc_done_cyc, mc_n_done);
    end
    n_chk++;
    if (mc_n_w !== 8 || mc_w_bad !== 0) begin
      n_fail++;
      $display("FAIL single_waddr: reads %0d bad %0d want 8 0", mc_n_w, mc_w_bad);
    end
    n_chk++;
    if (mc_n_exec !== 36 || mc_n_kload !== 8) begin
      n_fail++;
      $display("FAIL single_inst: exec %0d kload %0d want 36 8", mc_n_exec, mc_n_kload);
    end
    n_chk++;
    if (mc_n_wr !== 44 || mc_wr_bad !== 0) begin
      n_fail++;
      $display("FAIL single_l0wr: writes %0d bad %0d want 44 0", mc_n_wr, mc_wr_bad);
    end
    n_chk++;
    if (mc_n_a !== 36 || mc_a_bad !== 0) begin
      n_fail++;
      $display("FAIL single_aaddr: reads %0d bad %0d want 36 0", mc_n_a, mc_a_bad);
    end
    n_chk++;
    if (mc_n_sel !== 2 * ROW + 1 || mc_n_sfu !== OUT_DEPTH) begin
      n_fail++;
      $display("FAIL single_sel: sel %0d sfu %0d want %0d %0d", mc_n_sel, mc_n_sfu, 2 * ROW + 1, OUT_DEPTH);
    end
  endtask

  task automatic test_multi_pass();
    run_seq(8, 35, -10, 0, -10, 0, -10, -1);
    n_chk++;
    if (mc_timeout !== 0 || mc_done_cyc !== exp_done(8, 35, 0)) begin
      n_fail++;
      $display("FAIL multi_done: cycle %0d timeout %0d want %0d", mc_done_cyc, mc_timeout, exp_done(8, 35, 0));
    end
    n_chk++;
    if (mc_n_w !== 72 || mc_w_bad !== 0) begin
      n_fail++;
      $display("FAIL multi_waddr: reads %0d bad %0d want 72 0", mc_n_w, mc_w_bad);
    end
    n_chk++;
    if (mc_n_clr !== 9) begin
      n_fail++;
      $display("FAIL multi_clr: got %0d want 9", mc_n_clr);
    end
    n_chk++;
    if (mc_n_op !== OUT_DEPTH || mc_op_bad !== 0) begin
      n_fail++;
      $display("FAIL multi_wb: writes %0d bad %0d want %0d 0", mc_n_op, mc_op_bad, OUT_DEPTH);
    end
    n_chk++;
    if (mc_n_exec !== 9 * 36 || mc_n_a !== 9 * 36 || mc_a_bad !== 0) begin
      n_fail++;
      $display("FAIL multi_act: exec %0d reads %0d bad %0d want 324 324 0", mc_n_exec, mc_n_a, mc_a_bad);
    end
  endtask

  task automatic test_full_stall();
    run_seq(0, 35, A_LOAD0 + 7, 5, -10, 0, -10, -1);
    n_chk++;
    if (mc_done_cyc !== exp_done(0, 35, 5)) begin
      n_fail++;
      $display("FAIL full_len: got %0d want %0d", mc_done_cyc, exp_done(0, 35, 5));
    end
    n_chk++;
    if (mc_n_a !== 36 || mc_a_bad !== 0 || mc_stall_bad !== 0) begin
      n_fail++;
      $display("FAIL full_addr: reads %0d bad %0d stall %0d want 36 0 0", mc_n_a, mc_a_bad, mc_stall_bad);
    end
  endtask

  task automatic test_ready_stall();
    run_seq(0, 35, -10, 0, A_LOAD0 + 37 + 4, 3, -10, -1);
    n_chk++;
    if (mc_done_cyc !== exp_done(0, 35, 3)) begin
      n_fail++;
      $display("FAIL ready_len: got %0d want %0d", mc_done_cyc, exp_done(0, 35, 3));
    end
    n_chk++;
    if (mc_n_exec !== 36 || mc_stall_bad !== 0) begin
      n_fail++;
      $display("FAIL ready_exec: exec %0d stall %0d want 36 0", mc_n_exec, mc_stall_bad);
    end
  endtask

  task automatic test_abort();
    run_seq(0, 35, -10, 0, -10, 0, A_LOAD0 + 37 + 3, -1);
    n_chk++;
    if (mc_snap !== 11'b0_1_0_0_00_111_0_0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b want %b", mc_snap, 11'b0_1_0_0_00_111_0_0);
    end
    n_chk++;
    if (mc_snap2 !== 1'b0 || mc_n_done !== 0 || mc_timeout !== 0) begin
      n_fail++;
      $display("FAIL abort_after: clr %b done %0d timeout %0d want 0 0 0", mc_snap2, mc_n_done, mc_timeout);
    end
    run_seq(0, 3, -10, 0, -10, 0, -10, -1);
    n_chk++;
    if (mc_done_cyc !== exp_done(0, 3, 0) || mc_n_w !== 8 || mc_w_bad !== 0) begin
      n_fail++;
      $display("FAIL abort_restart: done %0d reads %0d bad %0d want %0d 8 0", mc_done_cyc, mc_n_w, mc_w_bad, exp_done(0, 3, 0));
    end
  endtask

  task automatic test_random();
    int k, n, fs, fl, rs, rl;
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(0, 8);
      n = $urandom_range(0, 63);
      fl = $urandom_range(0, 6);
      fs = A_LOAD0 + $urandom_range(0, n);
      rl = $urandom_range(0, 4);
      rs = A_LOAD0 + n + 2 + fl + $urandom_range(0, n);
      run_seq(k, n, fs, fl, rs, rl, -10, -1);
      n_chk++;
      if (mc_timeout !== 0 || mc_done_cyc !== exp_done(k, n, fl + rl)) begin
        n_fail++;
        $display("FAIL rand_len k=%0d n=%0d: got %0d want %0d", k, n, mc_done_cyc, exp_done(k, n, fl + rl));
      end
      n_chk++;
      if (mc_n_w !== (k + 1) * ROW || mc_w_bad !== 0 ||
          mc_n_a !== (k + 1) * (n + 1) || mc_a_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_reads k=%0d n=%0d: w %0d/%0d a %0d/%0d", k, n, mc_n_w, mc_w_bad, mc_n_a, mc_a_bad);
      end
      n_chk++;
      if (mc_n_exec !== (k + 1) * (n + 1) || mc_n_clr !== k + 1 ||
          mc_wr_bad !== 0 || mc_stall_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_strobes k=%0d n=%0d: exec %0d clr %0d wr %0d stall %0d", k, n, mc_n_exec, mc_n_clr, mc_wr_bad, mc_stall_bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] v;
    logic [20:0] a;
    run_seq(0, 35, -10, 0, -10, 0, -10, 120);
    n_chk++;
    if (sfu_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_wb: sfu_done %b want 1", sfu_done);
    end
    #2;
    reset_n = 1'b0;
    #1;
    v = {busy, seq_done, sfu_done, l0_wr, l0_rd, array_clr, inst_w,
         w_cen, act_cen, op_cen, op_wen, sel_w};
    a = {w_addr, act_addr, op_addr, out_sel};
    n_chk++;
    if (v !== 13'b000000_00_1111_0 || a !== 21'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: ctrl %b addr %h want %b 0", v, a, 13'b000000_00_1111_0);
    end
    seq_begin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_begin: busy %b want 0", busy);
    end
    seq_begin = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0 || op_cen !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_release: busy %b op_cen %b want 0 1", busy, op_cen);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    seq_begin = 1'b0;
    seq_abort = 1'b0;
    cfg_kij = '0;
    cfg_n_act = '0;
    l0_full = 1'b0;
    l0_ready = 1'b1;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_full_stall();
    test_ready_stall();
    test_abort();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
